request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/request_unit_if.sv | 37 +++
 rtl/request_unit.sv | 117 +++++++++++
 tb/tb_request_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/request_unit_if.sv
// Control/memory handshake bundle between the request unit (master) and the
// control unit, datapath and memory system (slave).
interface request_unit_if #(
    parameter int unsigned WORD_W = 32
);
    logic              iren;
    logic              dren;
    logic              dwen;
    logic              halt;
    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] iaddr_in;
    logic [WORD_W-1:0] daddr_in;
    logic [WORD_W-1:0] dstore_in;

    logic              imemREN;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] imemaddr;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              pc_en;
    logic              halted;
    logic              timeout;

    modport master (
        input  iren, dren, dwen, halt, ihit, dhit, iaddr_in, daddr_in, dstore_in,
        output imemREN, dmemREN, dmemWEN, imemaddr, dmemaddr, dmemstore,
               pc_en, halted, timeout
    );

    modport slave (
        output iren, dren, dwen, halt, ihit, dhit, iaddr_in, daddr_in, dstore_in,
        input  imemREN, dmemREN, dmemWEN, imemaddr, dmemaddr, dmemstore,
               pc_en, halted, timeout
    );
endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch and data access requests to memory, with a
// sticky halt state and a watchdog on unanswered requests.
module request_unit #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WORD_W   = 32
) (
    input  logic          CLK,
    input  logic          RST,
    request_unit_if.master bus
);
    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DATA,
        HALTED,
        ERR
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] iaddr_q, iaddr_d;
    logic [WORD_W-1:0] daddr_q, daddr_d;
    logic [WORD_W-1:0] dstore_q, dstore_d;
    logic              wr_q, wr_d;
    logic              wd_expired;
    logic              pc_en;

    // Fetch is issued in FETCH regardless of iren.
    logic unused_iren;
    assign unused_iren = bus.iren;

    assign wd_expired = (MAX_WAIT > 0) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iaddr_d  = iaddr_q;
        daddr_d  = daddr_q;
        dstore_d = dstore_q;
        wr_d     = wr_q;
        pc_en    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                iaddr_d = bus.iaddr_in;
                if (bus.ihit) begin
                    cnt_d = '0;
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else if (bus.dren || bus.dwen) begin
                        state_d  = DATA;
                        daddr_d  = bus.daddr_in;
                        dstore_d = bus.dstore_in;
                        wr_d     = bus.dwen;
                    end else begin
                        pc_en = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d = ERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bus.dhit) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    pc_en   = 1'b1;
                end else if (wd_expired) begin
                    state_d = ERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALTED:  state_d = HALTED;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            iaddr_q  <= '0;
            daddr_q  <= '0;
            dstore_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            iaddr_q  <= iaddr_d;
            daddr_q  <= daddr_d;
            dstore_q <= dstore_d;
            wr_q     <= wr_d;
        end
    end

    // Outside FETCH the instruction address shows the last PC presented.
    assign bus.imemREN   = (state_q == FETCH);
    assign bus.imemaddr  = (state_q == FETCH) ? bus.iaddr_in : iaddr_q;
    assign bus.dmemREN   = (state_q == DATA) && !wr_q;
    assign bus.dmemWEN   = (state_q == DATA) && wr_q;
    assign bus.dmemaddr  = daddr_q;
    assign bus.dmemstore = dstore_q;
    assign bus.pc_en     = pc_en;
    assign bus.halted    = (state_q == HALTED);
    assign bus.timeout   = (state_q == ERR);
endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: per-cycle comparison against a transaction-level
// model plus directed checks, including two watchdog-configured instances.
module tb_request_unit;
    localparam int MW = 255;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    request_unit_if #(.WORD_W(32)) bus ();
    request_unit_if #(.WORD_W(32)) wd4 ();
    request_unit_if #(.WORD_W(32)) wd0 ();

    request_unit #(.MAX_WAIT(MW), .WORD_W(32)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));
    request_unit #(.MAX_WAIT(4),  .WORD_W(32)) u_wd4 (.CLK(CLK), .RST(RST), .bus(wd4));
    request_unit #(.MAX_WAIT(0),  .WORD_W(32)) u_wd0 (.CLK(CLK), .RST(RST), .bus(wd0));

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: which phase of the fetch/data conversation we are in, how long
    // the pending request has waited, and what was captured for the data access.
    typedef enum int {M_IDLE, M_FETCH, M_DATA, M_HALTED, M_ERR} mphase_e;
    mphase_e     m_ph    = M_IDLE;
    int          m_wait  = 0;
    logic [31:0] m_ilast = '0;
    logic [31:0] m_daddr = '0;
    logic [31:0] m_dstore = '0;
    logic        m_wr    = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_ph <= M_IDLE; m_wait <= 0; m_ilast <= '0;
            m_daddr <= '0; m_dstore <= '0; m_wr <= 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: begin m_ph <= M_FETCH; m_wait <= 0; end
                M_FETCH: begin
                    m_ilast <= bus.iaddr_in;
                    if (bus.ihit) begin
                        m_wait <= 0;
                        if (bus.halt) m_ph <= M_HALTED;
                        else if (bus.dren || bus.dwen) begin
                            m_ph <= M_DATA; m_daddr <= bus.daddr_in;
                            m_dstore <= bus.dstore_in; m_wr <= bus.dwen;
                        end
                    end else if (MW > 0 && m_wait >= MW) begin
                        m_ph <= M_ERR; m_wait <= 0;
                    end else m_wait <= m_wait + 1;
                end
                M_DATA: begin
                    if (bus.dhit) begin m_ph <= M_FETCH; m_wait <= 0; end
                    else if (MW > 0 && m_wait >= MW) begin m_ph <= M_ERR; m_wait <= 0; end
                    else m_wait <= m_wait + 1;
                end
                default: ;
            endcase
        end
    end

    always @(negedge CLK) begin
        logic fetch, data, exp_pc;
        fetch  = (m_ph == M_FETCH);
        data   = (m_ph == M_DATA);
        exp_pc = (fetch && bus.ihit && !bus.halt && !bus.dren && !bus.dwen) || (data && bus.dhit);
        check("m.imemREN",   64'(bus.imemREN),   64'(fetch));
        check("m.imemaddr",  64'(bus.imemaddr),  64'(fetch ? bus.iaddr_in : m_ilast));
        check("m.dmemREN",   64'(bus.dmemREN),   64'(data && !m_wr));
        check("m.dmemWEN",   64'(bus.dmemWEN),   64'(data && m_wr));
        check("m.dmemaddr",  64'(bus.dmemaddr),  64'(m_daddr));
        check("m.dmemstore", 64'(bus.dmemstore), 64'(m_dstore));
        check("m.pc_en",     64'(bus.pc_en),     64'(exp_pc));
        check("m.halted",    64'(bus.halted),    64'(m_ph == M_HALTED));
        check("m.timeout",   64'(bus.timeout),   64'(m_ph == M_ERR));
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic ctl_zero();
        bus.ihit = 0; bus.dhit = 0; bus.halt = 0; bus.dren = 0; bus.dwen = 0;
    endtask

    initial begin
        int t4, t255;
        logic wd0_fired;
        bus.iren = 1; ctl_zero();
        bus.iaddr_in = '0; bus.daddr_in = '0; bus.dstore_in = '0;
        wd4.iren = 0; wd4.dren = 0; wd4.dwen = 0; wd4.halt = 0; wd4.ihit = 0; wd4.dhit = 0;
        wd4.iaddr_in = 32'h40; wd4.daddr_in = '0; wd4.dstore_in = '0;
        wd0.iren = 0; wd0.dren = 0; wd0.dwen = 0; wd0.halt = 0; wd0.ihit = 0; wd0.dhit = 0;
        wd0.iaddr_in = 32'h80; wd0.daddr_in = '0; wd0.dstore_in = '0;

        repeat (2) @(negedge CLK);
        #1;
        check("rst.imemREN",  64'(bus.imemREN),  64'(0));
        check("rst.imemaddr", 64'(bus.imemaddr), 64'(0));
        check("rst.dmemaddr", 64'(bus.dmemaddr), 64'(0));
        check("rst.halted",   64'(bus.halted),   64'(0));
        #1 RST = 0;

        // Plain fetch, iren low is still a fetch
        bus.iren = 0;
        cyc(); #1;
        check("f.imemREN.c1", 64'(bus.imemREN), 64'(1));
        check("f.pc_en.c1",   64'(bus.pc_en),   64'(0));
        cyc(); bus.ihit = 1; #1;
        check("f.pc_en.hit",  64'(bus.pc_en),   64'(1));
        cyc(); bus.ihit = 0; bus.iren = 1; #1;
        check("f.pc_en.after", 64'(bus.pc_en),  64'(0));
        check("f.stay.fetch",  64'(bus.imemREN), 64'(1));
        cyc(); bus.iaddr_in = 32'h4; bus.ihit = 1; bus.dhit = 1; #1;
        check("f.imemaddr",   64'(bus.imemaddr), 64'h4);

        // Load, dhit on the 4th DATA cycle while daddr_in keeps changing
        cyc(); bus.dhit = 0; bus.iaddr_in = 32'h8; bus.dren = 1;
        bus.daddr_in = 32'h100; bus.dstore_in = 32'h55; #1;
        check("ld.pc_en.issue", 64'(bus.pc_en), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.ihit = (i == 1); bus.dren = 0;
            bus.daddr_in = (i % 2 == 0) ? 32'hFFC : 32'h200; #1;
            check("ld.dmemaddr", 64'(bus.dmemaddr), 64'h100);
            check("ld.dmemREN",  64'(bus.dmemREN),  64'(1));
            check("ld.imemREN",  64'(bus.imemREN),  64'(0));
        end
        cyc(); bus.ihit = 0; bus.dhit = 1; #1;
        check("ld.pc_en.dhit", 64'(bus.pc_en), 64'(1));
        cyc(); bus.dhit = 0; bus.iaddr_in = 32'hC; #1;
        check("ld.back.fetch", 64'(bus.imemREN),  64'(1));
        check("ld.imemaddr",   64'(bus.imemaddr), 64'hC);

        // Store with both dren and dwen set
        cyc(); bus.ihit = 1; bus.dren = 1; bus.dwen = 1;
        bus.daddr_in = 32'h300; bus.dstore_in = 32'hDEADBEEF; #1;
        check("st.pc_en.issue", 64'(bus.pc_en), 64'(0));
        for (int i = 0; i < 2; i++) begin
            cyc(); ctl_zero(); bus.dstore_in = 32'h12345678 + 32'(i); #1;
            check("st.dmemWEN",   64'(bus.dmemWEN),   64'(1));
            check("st.dmemREN",   64'(bus.dmemREN),   64'(0));
            check("st.dmemstore", 64'(bus.dmemstore), 64'hDEADBEEF);
        end
        cyc(); bus.dhit = 1; #1;
        check("st.pc_en.dhit", 64'(bus.pc_en), 64'(1));
        cyc(); #1;
        check("st.dhit.fetch.ign", 64'(bus.pc_en), 64'(0));

        // Asynchronous reset in the middle of a load
        cyc(); bus.dhit = 0; bus.ihit = 1; bus.dren = 1; bus.daddr_in = 32'h400;
        cyc(); bus.ihit = 0; bus.dren = 0; #1;
        check("ar.dmemREN.before", 64'(bus.dmemREN), 64'(1));
        bus.dhit = 1;
        #1 RST = 1;
        #1;
        check("ar.dmemREN.drop", 64'(bus.dmemREN), 64'(0));
        check("ar.pc_en.drop",   64'(bus.pc_en),   64'(0));
        check("ar.dmemaddr",     64'(bus.dmemaddr), 64'(0));
        @(posedge CLK); #3;
        check("ar.pc_en.held", 64'(bus.pc_en), 64'(0));
        @(negedge CLK); #2 RST = 0; #1;
        check("ar.idle.imemREN", 64'(bus.imemREN), 64'(0));
        cyc(); #1;
        check("ar.fetch.imemREN", 64'(bus.imemREN), 64'(1));
        check("ar.fetch.pc_en",   64'(bus.pc_en),   64'(0));

        // Halt, then hits and requests are ignored
        cyc(); bus.dhit = 0; bus.ihit = 1; bus.halt = 1; #1;
        check("h.pc_en", 64'(bus.pc_en), 64'(0));
        cyc(); ctl_zero(); #1;
        check("h.halted", 64'(bus.halted), 64'(1));
        for (int i = 0; i < 20; i++) begin
            cyc(); bus.ihit = (i % 2 == 0); bus.dhit = (i % 2 == 1); bus.dren = (i % 3 == 0); #1;
            check("h.reqs", 64'({bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pc_en}), 64'(0));
        end
        ctl_zero();
        RST = 1; #1;
        check("h.rst.clears", 64'(bus.halted), 64'(0));

        // Watchdog: 4, 0 (disabled) and default 255 with no hit ever
        @(negedge CLK); #2 RST = 0;
        t4 = 0; t255 = 0; wd0_fired = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge CLK); #1;
            if (wd4.timeout && t4 == 0) t4 = i;
            if (bus.timeout && t255 == 0) t255 = i;
            if (wd0.timeout) wd0_fired = 1;
            if (i == 5) check("wd4.imemREN.before", 64'(wd4.imemREN), 64'(1));
            if (i == 10) begin wd4.ihit = 1; wd4.dhit = 1; end
        end
        check("wd4.edge",       64'(t4),   64'(6));
        check("wd4.imemREN",    64'(wd4.imemREN), 64'(0));
        check("wd4.sticky",     64'(wd4.timeout), 64'(1));
        check("wd255.edge",     64'(t255), 64'(257));
        check("wd0.never",      64'(wd0_fired), 64'(0));
        check("wd0.imemREN",    64'(wd0.imemREN), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
